// File: rtl/nubus_pkg.sv
// Shared types and encodings for the NuBus slave: state enum, TM status codes
// and the {tm0n, AD[1:0]} transfer-size encodings.
package nubus_pkg;

   localparam logic [3:0] SLOT_SPACE_DEFAULT = 4'hF;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WDATA = 2'd1,
      ST_MEM   = 2'd2,
      ST_ACK   = 2'd3
   } state_t;

   // Status as driven on {tm1n_o, tm0n_o}
   typedef logic [1:0] status_t;
   localparam status_t STAT_COMPLETE = 2'b00;
   localparam status_t STAT_ERROR    = 2'b01;
   localparam status_t STAT_TIMEOUT  = 2'b10;

   // AD[1:0] meaning when tm0n is high (non-byte transfers)
   localparam logic [1:0] LANE_HALF_HI = 2'b00;
   localparam logic [1:0] LANE_BLOCK   = 2'b01;
   localparam logic [1:0] LANE_HALF_LO = 2'b10;
   localparam logic [1:0] LANE_WORD    = 2'b11;

   function automatic logic [3:0] byte_lane(input logic [1:0] lane);
      return 4'b0001 << lane;
   endfunction

endpackage

// File: rtl/nubus_slave_if.sv
// Bus-side and local-memory-side signals of the NuBus slave, with the slave
// (DUT) view and the master (environment) view.
interface nubus_slave_if;
   logic [3:0]  nub_idn;
   logic        nub_startn;
   logic        nub_ackn;
   logic        nub_tm1n;
   logic        nub_tm0n;
   logic [31:0] nub_adn;
   logic        ack_oe;
   logic        tm_oe;
   logic        tm1n_o;
   logic        tm0n_o;
   logic        ad_oe;
   logic [31:0] adn_o;
   // mem_valid rises with a request and stays high until a cycle with
   // mem_ready high; mem_rdata is taken on that same edge.
   logic        mem_valid;
   logic        mem_write;
   logic [21:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic        mem_ready;
   logic [31:0] mem_rdata;

   modport slave (
      input  nub_idn, nub_startn, nub_ackn, nub_tm1n, nub_tm0n, nub_adn,
      input  mem_ready, mem_rdata,
      output ack_oe, tm_oe, tm1n_o, tm0n_o, ad_oe, adn_o,
      output mem_valid, mem_write, mem_addr, mem_be, mem_wdata
   );

   modport master (
      output nub_idn, nub_startn, nub_ackn, nub_tm1n, nub_tm0n, nub_adn,
      output mem_ready, mem_rdata,
      input  ack_oe, tm_oe, tm1n_o, tm0n_o, ad_oe, adn_o,
      input  mem_valid, mem_write, mem_addr, mem_be, mem_wdata
   );
endinterface

// File: rtl/nubus_lane_decode.sv
// Combinational decode of {tm0n, AD[1:0]} into local byte enables and a flag
// for the unsupported block transfer.
module nubus_lane_decode
   import nubus_pkg::*;
(
   input  logic       tm0n,
   input  logic [1:0] lane,
   output logic [3:0] be,
   output logic       block
);

   always_comb begin
      be    = 4'b0000;
      block = 1'b0;
      if (!tm0n) begin
         be = byte_lane(lane);
      end else begin
         case (lane)
            LANE_WORD:    be = 4'b1111;
            LANE_HALF_LO: be = 4'b0011;
            LANE_HALF_HI: be = 4'b1100;
            default:      block = 1'b1;
         endcase
      end
   end

endmodule

// File: rtl/nubus_slave.sv
// NuBus slave: decodes slot-space STARTs, runs one local memory access and
// answers with a one-cycle ACK. NUBUS_SLAVE_TIMEOUT_EN adds a local wait timeout.
module nubus_slave
   import nubus_pkg::*;
#(
   parameter logic [3:0] SLOT_SPACE     = SLOT_SPACE_DEFAULT,
   parameter logic [7:0] TIMEOUT_CYCLES = 8'd255
) (
   input  logic         nub_clkn,
   input  logic         nub_reset,
   nubus_slave_if.slave bus,
   output state_t       state_dbg
);

   state_t      state;
   logic [31:0] ad;
   logic [3:0]  slot;
   logic        start_cycle;
   logic        hit;
   logic [3:0]  lane_be;
   logic        lane_block;

   // Bus lines are active low; work on true-polarity copies.
   assign ad          = ~bus.nub_adn;
   assign slot        = ~bus.nub_idn;
   assign start_cycle = ~bus.nub_startn & bus.nub_ackn;
   assign hit         = start_cycle && (ad[31:28] == SLOT_SPACE) && (ad[27:24] == slot);
   assign state_dbg   = state;

   nubus_lane_decode u_lane (
      .tm0n  (bus.nub_tm0n),
      .lane  (ad[1:0]),
      .be    (lane_be),
      .block (lane_block)
   );

`ifdef NUBUS_SLAVE_TIMEOUT_EN
   logic [7:0] wait_cnt;
   logic       expired;
   assign expired = (wait_cnt == TIMEOUT_CYCLES - 8'd1);
`else
   logic unused_timeout;
   assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

   always_ff @(posedge nub_clkn or posedge nub_reset) begin
      if (nub_reset) begin
         state         <= ST_IDLE;
         bus.ack_oe    <= 1'b0;
         bus.tm_oe     <= 1'b0;
         bus.ad_oe     <= 1'b0;
         bus.tm1n_o    <= 1'b1;
         bus.tm0n_o    <= 1'b1;
         bus.adn_o     <= '1;
         bus.mem_valid <= 1'b0;
         bus.mem_write <= 1'b0;
         bus.mem_addr  <= '0;
         bus.mem_be    <= '0;
         bus.mem_wdata <= '0;
`ifdef NUBUS_SLAVE_TIMEOUT_EN
         wait_cnt      <= '0;
`endif
      end else begin
         case (state)
            ST_IDLE: begin
               if (hit) begin
                  bus.mem_addr  <= ad[23:2];
                  bus.mem_be    <= lane_be;
                  bus.mem_write <= bus.nub_tm1n;
                  bus.adn_o     <= '1;
                  if (lane_block) begin
                     state                    <= ST_ACK;
                     bus.ack_oe               <= 1'b1;
                     bus.tm_oe                <= 1'b1;
                     bus.ad_oe                <= ~bus.nub_tm1n;
                     {bus.tm1n_o, bus.tm0n_o} <= STAT_ERROR;
                  end else if (bus.nub_tm1n) begin
                     state <= ST_WDATA;
                  end else begin
                     state         <= ST_MEM;
                     bus.mem_valid <= 1'b1;
`ifdef NUBUS_SLAVE_TIMEOUT_EN
                     wait_cnt      <= '0;
`endif
                  end
               end
            end
            ST_WDATA: begin
               bus.mem_wdata <= ~bus.nub_adn;
               bus.mem_valid <= 1'b1;
               state         <= ST_MEM;
`ifdef NUBUS_SLAVE_TIMEOUT_EN
               wait_cnt      <= '0;
`endif
            end
            ST_MEM: begin
               // mem_ready is checked first so it wins over a same-edge expiry.
               if (bus.mem_ready) begin
                  state                    <= ST_ACK;
                  bus.mem_valid            <= 1'b0;
                  bus.ack_oe               <= 1'b1;
                  bus.tm_oe                <= 1'b1;
                  bus.ad_oe                <= ~bus.mem_write;
                  {bus.tm1n_o, bus.tm0n_o} <= STAT_COMPLETE;
                  if (!bus.mem_write) begin
                     bus.adn_o <= ~bus.mem_rdata;
                  end
               end
`ifdef NUBUS_SLAVE_TIMEOUT_EN
               else if (expired) begin
                  state                    <= ST_ACK;
                  bus.mem_valid            <= 1'b0;
                  bus.ack_oe               <= 1'b1;
                  bus.tm_oe                <= 1'b1;
                  bus.ad_oe                <= ~bus.mem_write;
                  {bus.tm1n_o, bus.tm0n_o} <= STAT_TIMEOUT;
               end else begin
                  wait_cnt <= wait_cnt + 8'd1;
               end
`endif
            end
            ST_ACK: begin
               state      <= ST_IDLE;
               bus.ack_oe <= 1'b0;
               bus.tm_oe  <= 1'b0;
               bus.ad_oe  <= 1'b0;
               bus.tm1n_o <= 1'b1;
               bus.tm0n_o <= 1'b1;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
